// File: rtl/common_pkg.sv
// common: shared bus/memory request and response types plus arbiter state encoding
package common;
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;
  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;
  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;
  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } mem_req_t;
  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } mem_resp_t;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} arb_state_t;
  localparam logic [2:0] MSIZE4 = 3'b010;
  localparam logic [2:0] MSIZE8 = 3'b011;
endpackage

// File: rtl/mem_port_arbiter_fairness.sv
// arb_fairness: dbus-first grant decision with a streak limit that lets a waiting ibus through
module arb_fairness #(
  parameter int MAX_D_STREAK = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_valid,
  input  logic d_valid,
  input  logic arb_en,
  output logic grant_i,
  output logic grant_d
);
  localparam int W = $clog2(MAX_D_STREAK + 1);
  localparam logic [W-1:0] MAX = W'(MAX_D_STREAK);
  logic [W-1:0] streak;
  assign grant_d = arb_en && d_valid && (!i_valid || streak < MAX);
  assign grant_i = arb_en && i_valid && !grant_d;
  // streak counts dbus wins only while ibus is kept waiting
  always_ff @(posedge clk) begin
    if (reset) streak <= '0;
    else if (grant_d) streak <= i_valid ? streak + W'(1) : '0;
    else if (grant_i) streak <= '0;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one downstream memory port between ibus and dbus, one transaction at a time
module mem_port_arbiter
  import common::*;
#(
  parameter int MAX_D_STREAK = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output mem_req_t   oreq,
  input  mem_resp_t  oresp
);
  arb_state_t  state;
  logic        owner_i;
  mem_req_t    req;
  logic [63:0] rdata;
  logic        grant_i, grant_d;
  arb_fairness #(.MAX_D_STREAK(MAX_D_STREAK)) u_fair (
    .clk(clk),
    .reset(reset),
    .i_valid(ireq.valid),
    .d_valid(dreq.valid),
    .arb_en(state == IDLE),
    .grant_i(grant_i),
    .grant_d(grant_d)
  );
  // outputs are pure decodes of state and latched registers
  always_comb begin
    oreq = req;
    oreq.valid = state == REQ;
    iresp = (state == RESP && owner_i) ? '{1'b1, 1'b1, req.addr[2] ? rdata[63:32] : rdata[31:0]} : '0;
    dresp = (state == RESP && !owner_i) ? '{1'b1, 1'b1, rdata} : '0;
  end
  // arbitrate in IDLE, then hold the grant until downstream returns data
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      owner_i <= 1'b0;
      req <= '0;
      rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            owner_i <= 1'b0;
            req <= '{1'b0, |dreq.strobe, dreq.addr, dreq.size, dreq.strobe, dreq.data};
            state <= REQ;
          end else if (grant_i) begin
            owner_i <= 1'b1;
            req <= '{1'b0, 1'b0, ireq.addr, MSIZE4, 8'h00, 64'h0};
            state <= REQ;
          end
        end
        REQ: begin
          if (oresp.addr_ok) begin
            state <= oresp.data_ok ? RESP : WAIT;
            if (oresp.data_ok) rdata <= oresp.data;
          end
        end
        WAIT: begin
          if (oresp.data_ok) begin
            state <= RESP;
            rdata <= oresp.data;
          end
        end
        RESP: state <= IDLE;
      endcase
    end
  end
endmodule
